mux_sel_sched: RTL and testbench

- Round-robin scheduler directly upstream of the 4x1 MUX.
- Arbitrates four channel request lines and drives the MUX select (`sel`) and enable (`en`).
- Holds each granted channel for a fixed burst of accepted beats, then inserts a one-cycle gap before re-arbitrating.
- Consumer handshakes each beat with `ack`.

---
 rtl/mux_sel_sched.sv | 95 +++++++++
 tb/tb_mux_sel_sched.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/mux_sel_sched.sv
// rtl/mux_sel_sched.sv - round-robin burst scheduler driving a 4x1 mux select/enable
module mux_sel_sched #(
  parameter int HOLD  = 4,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       req,
  input  logic             ack,
  output logic [1:0]       sel,
  output logic             en,
  output logic [3:0]       grant,
  output logic [CNT_W-1:0] beat,
  output logic             last,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] BEAT_LAST = CNT_W'(HOLD - 1);

  state_t     state;
  logic [1:0] ptr;
  logic [1:0] win;
  logic       win_vld;
  logic       final_beat;

  // Round-robin search starting just after the last granted channel, so the
  // previous winner is considered last.
  always_comb begin
    win     = 2'd0;
    win_vld = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      logic [1:0] idx;
      idx = ptr + 2'(i);
      if (!win_vld && req[idx]) begin
        win     = idx;
        win_vld = 1'b1;
      end
    end
  end

  assign final_beat = ack && (beat == BEAT_LAST);

  // Burst completion strobe follows the live ack, so it is combinational.
  assign last = en & final_beat;
  assign busy = (state != IDLE);

  // Scheduler FSM: IDLE arbitrates, GRANT counts accepted beats, GAP idles one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      sel   <= 2'd0;
      en    <= 1'b0;
      grant <= 4'd0;
      beat  <= '0;
      ptr   <= 2'd3;
    end else begin
      case (state)
        IDLE: begin
          if (win_vld) begin
            sel   <= win;
            grant <= 4'b0001 << win;
            en    <= 1'b1;
            beat  <= '0;
            ptr   <= win;
            state <= GRANT;
          end
        end
        GRANT: begin
          // A dropped request aborts the burst; it and the final beat both end in GAP.
          if (!req[sel] || final_beat) begin
            en    <= 1'b0;
            grant <= 4'd0;
            beat  <= '0;
            state <= GAP;
          end else if (ack) begin
            beat <= beat + 1'b1;
          end
        end
        GAP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux_sel_sched.sv
// tb/tb_mux_sel_sched.sv - directed self-checking bench for mux_sel_sched
module tb_mux_sel_sched;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic       ack;
  logic [1:0] sel;
  logic       en;
  logic [3:0] grant;
  logic [3:0] beat;
  logic       last;
  logic       busy;

  int n_cmp = 0;
  int n_bad = 0;

  mux_sel_sched #(.HOLD(4), .CNT_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .ack   (ack),
    .sel   (sel),
    .en    (en),
    .grant (grant),
    .beat  (beat),
    .last  (last),
    .busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    check("rst_sel", sel, 0);
    check("rst_en", en, 0);
    check("rst_grant", grant, 0);
    check("rst_beat", beat, 0);
    check("rst_busy", busy, 0);
    check("rst_last", last, 0);
    rst_n = 1'b1;
  endtask

  task automatic wait_grant(output int lows);
    lows = 0;
    while (!en && lows < 16) begin
      tick();
      lows++;
    end
    check("en_rise", en, 1);
  endtask

  task automatic hold_grant(output int highs, output int lasts);
    highs = 0;
    lasts = 0;
    while (en && highs < 32) begin
      if (last) lasts++;
      highs++;
      tick();
    end
  endtask

  int lows, highs, lasts;
  int exp_sel_rr [5] = '{0, 1, 2, 3, 0};
  int ack_pat    [7] = '{1, 0, 0, 1, 1, 0, 1};
  int beat_pat   [7] = '{0, 1, 1, 1, 2, 3, 3};

  initial begin
    rst_n = 1'b1;
    req   = 4'd0;
    ack   = 1'b0;
    #1;

    // Single requester, ack every cycle.
    do_reset();
    req = 4'b0001;
    ack = 1'b1;
    tick();
    check("t1_en", en, 1);
    check("t1_sel", sel, 0);
    check("t1_grant", grant, 1);
    for (int b = 0; b < 4; b++) begin
      check("t1_beat", beat, b);
      check("t1_last", last, (b == 3) ? 1 : 0);
      tick();
    end
    check("t1_gap_en", en, 0);
    check("t1_gap_busy", busy, 1);
    check("t1_gap_grant", grant, 0);
    check("t1_gap_beat", beat, 0);
    tick();
    check("t1_idle_busy", busy, 0);
    check("t1_idle_en", en, 0);
    tick();
    check("t1_regrant_en", en, 1);
    check("t1_regrant_sel", sel, 0);

    // All four requesting: rotate 0,1,2,3,0.
    do_reset();
    req = 4'b1111;
    ack = 1'b1;
    for (int k = 0; k < 5; k++) begin
      wait_grant(lows);
      if (k > 0) check("t2_gap_cycles", lows, 2);
      check("t2_sel", sel, exp_sel_rr[k]);
      check("t2_grant", grant, 1 << exp_sel_rr[k]);
      hold_grant(highs, lasts);
      check("t2_beats", highs, 4);
      check("t2_lasts", lasts, 1);
    end

    // Stalling consumer on channel 1.
    do_reset();
    req = 4'b0010;
    ack = 1'b0;
    tick();
    check("t3_sel", sel, 1);
    for (int i = 0; i < 7; i++) begin
      ack = ack_pat[i][0];
      #1;
      check("t3_en", en, 1);
      check("t3_beat", beat, beat_pat[i]);
      check("t3_last", last, (i == 6) ? 1 : 0);
      tick();
    end
    ack = 1'b0;
    check("t3_end_en", en, 0);

    // Abort on channel 2 after two beats; channel 3 pending.
    req = 4'b0100;
    ack = 1'b1;
    wait_grant(lows);
    check("t4_sel", sel, 2);
    tick();
    tick();
    check("t4_beat", beat, 2);
    req = 4'b1000;
    #1;
    check("t4_abort_last", last, 0);
    tick();
    ack = 1'b0;
    check("t4_gap_en", en, 0);
    check("t4_gap_busy", busy, 1);
    check("t4_gap_beat", beat, 0);
    tick();
    check("t4_idle_busy", busy, 0);
    tick();
    check("t4_next_en", en, 1);
    check("t4_next_sel", sel, 3);
    check("t4_next_grant", grant, 8);

    // Asynchronous reset mid-grant.
    ack = 1'b1;
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_en", en, 0);
    check("t5_grant", grant, 0);
    check("t5_beat", beat, 0);
    check("t5_busy", busy, 0);
    req = 4'b1010;
    ack = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    check("t5_en_after", en, 1);
    check("t5_sel_after", sel, 1);

    // Drop requests, then ack pulses in GAP/IDLE must be ignored.
    req = 4'b0000;
    for (int i = 0; i < 6; i++) begin
      ack = i[0];
      tick();
      ack = ~i[0];
      #1;
      check("t6_en", en, 0);
      check("t6_beat", beat, 0);
      check("t6_last", last, 0);
      check("t6_sel", sel, 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
